// File: rtl/modexp_operand_loader.sv
// -----------------------------------------------------------------------------
// modexp_operand_loader
//
// Upstream feeder for the ModExp datapath. A framed host word stream
// (valid/ready) is deframed into the operand stores:
//   C, N, R, T : written word-serially into the external b_ram stores
//   D          : buffered internally, streamed on d_in0 during ModExp LOADC
//   N0         : held in a register on n0_in
// A GO frame runs START -> STREAM -> GAP -> KICK, which produces startInput,
// the D stream and the two-cycle startCompute pulse.
//
// Handshake: a word transfers on any rising clk edge where s_valid && s_ready
// are both high. s_ready is registered; it is 1 in IDLE/LOAD/DRAIN and 0
// during reset and throughout a GO sequence. s_data/s_last must be stable
// while s_valid is high and the word has not yet transferred.
//
// Frame = header word + payload. Header opcode is s_data[3:0]:
//   0=C 1=N 2=R 3=T 4=D (TOTAL_ADDR words each), 5=N0 (1 word),
//   6=GO (no payload), 7=CLR (no payload, clears loaded and err).
//
// Ports:
//   clk, reset         clock, asynchronous active-high reset
//   s_valid/s_ready    input word handshake
//   s_data, s_last     input word and end-of-frame marker
//   c/n/r/t_wren       one-cycle write strobes to the operand stores
//   waddr              operand store write address
//   c_n_datain         write data for C/N stores
//   r_t_datain         write data for R/T stores
//   n0_in              held N0 word
//   d_in0              exponent word stream during LOADC (0 otherwise)
//   startInput         one-cycle pulse opening ModExp LOADC
//   startCompute       two-cycle pulse releasing ModExp from WAIT_COMPUTE
//   loaded             sticky valid mask {N0,D,T,R,N,C}
//   busy               GO sequence in progress
//   err                sticky framing error
//   state_dbg          current FSM state encoding (debug observation)
//
// Build option: define MODEXP_LOADER_MSW_FIRST_EN when payload frames arrive
// most-significant word first. Word k then lands at address TOTAL_ADDR-1-k
// (C/N/R/T stores and the D buffer); the d_in0 order stays D[0] first and N0
// is unaffected. Undefined (default): least-significant word first.
// -----------------------------------------------------------------------------
module modexp_operand_loader #(
    parameter int DATA_WIDTH = 64,
    parameter int TOTAL_ADDR = 32,
    parameter int ADDR_W     = $clog2(TOTAL_ADDR)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    output logic                  c_wren,
    output logic                  n_wren,
    output logic                  r_wren,
    output logic                  t_wren,
    output logic [ADDR_W-1:0]     waddr,
    output logic [DATA_WIDTH-1:0] c_n_datain,
    output logic [DATA_WIDTH-1:0] r_t_datain,
    output logic [DATA_WIDTH-1:0] n0_in,
    output logic [DATA_WIDTH-1:0] d_in0,
    output logic                  startInput,
    output logic                  startCompute,
    output logic [5:0]            loaded,
    output logic                  busy,
    output logic                  err,
    output logic [2:0]            state_dbg
);

    localparam logic [3:0] OP_C   = 4'd0;
    localparam logic [3:0] OP_N   = 4'd1;
    localparam logic [3:0] OP_R   = 4'd2;
    localparam logic [3:0] OP_T   = 4'd3;
    localparam logic [3:0] OP_D   = 4'd4;
    localparam logic [3:0] OP_N0  = 4'd5;
    localparam logic [3:0] OP_GO  = 4'd6;
    localparam logic [3:0] OP_CLR = 4'd7;

    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(TOTAL_ADDR - 1);
    localparam logic [5:0]        ALL_LOADED = 6'h3F;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_START  = 3'd3,
        ST_STREAM = 3'd4,
        ST_GAP    = 3'd5,
        ST_KICK   = 3'd6
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            op_q, op_d;
    logic [ADDR_W-1:0]     cnt_q, cnt_d;
    logic [ADDR_W-1:0]     last_idx_q, last_idx_d;
    logic [5:0]            loaded_q, loaded_d;
    logic                  err_q, err_d;
    logic                  s_ready_q, s_ready_d;
    logic                  c_wren_q, c_wren_d;
    logic                  n_wren_q, n_wren_d;
    logic                  r_wren_q, r_wren_d;
    logic                  t_wren_q, t_wren_d;
    logic [ADDR_W-1:0]     waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0] c_n_q, c_n_d;
    logic [DATA_WIDTH-1:0] r_t_q, r_t_d;
    logic [DATA_WIDTH-1:0] n0_q, n0_d;

    // Exponent buffer: no reset, its contents survive reset until reloaded.
    logic [DATA_WIDTH-1:0] d_mem_q [TOTAL_ADDR];
    logic                  d_we;
    logic [ADDR_W-1:0]     d_waddr;
    logic [DATA_WIDTH-1:0] d_wdata;

    logic                  accept;
    logic [ADDR_W-1:0]     wr_addr;
    logic [5:0]            op_mask;
    logic [5:0]            hdr_mask;

    always_comb begin
        accept   = s_valid & s_ready_q;
        op_mask  = 6'd1 << op_q;
        hdr_mask = 6'd1 << s_data[3:0];
`ifdef MODEXP_LOADER_MSW_FIRST_EN
        wr_addr = LAST_WORD - cnt_q;
`else
        wr_addr = cnt_q;
`endif
    end

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            op_q       <= '0;
            cnt_q      <= '0;
            last_idx_q <= '0;
            loaded_q   <= '0;
            err_q      <= 1'b0;
            s_ready_q  <= 1'b0;
            c_wren_q   <= 1'b0;
            n_wren_q   <= 1'b0;
            r_wren_q   <= 1'b0;
            t_wren_q   <= 1'b0;
            waddr_q    <= '0;
            c_n_q      <= '0;
            r_t_q      <= '0;
            n0_q       <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            cnt_q      <= cnt_d;
            last_idx_q <= last_idx_d;
            loaded_q   <= loaded_d;
            err_q      <= err_d;
            s_ready_q  <= s_ready_d;
            c_wren_q   <= c_wren_d;
            n_wren_q   <= n_wren_d;
            r_wren_q   <= r_wren_d;
            t_wren_q   <= t_wren_d;
            waddr_q    <= waddr_d;
            c_n_q      <= c_n_d;
            r_t_q      <= r_t_d;
            n0_q       <= n0_d;
        end
    end

    always_ff @(posedge clk) begin
        if (d_we) begin
            d_mem_q[d_waddr] <= d_wdata;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and datapath updates
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        cnt_d      = cnt_q;
        last_idx_d = last_idx_q;
        loaded_d   = loaded_q;
        err_d      = err_q;
        c_wren_d   = 1'b0;
        n_wren_d   = 1'b0;
        r_wren_d   = 1'b0;
        t_wren_d   = 1'b0;
        waddr_d    = waddr_q;
        c_n_d      = c_n_q;
        r_t_d      = r_t_q;
        n0_d       = n0_q;
        d_we       = 1'b0;
        d_waddr    = wr_addr;
        d_wdata    = s_data;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    cnt_d = '0;
                    unique case (s_data[3:0])
                        OP_C, OP_N, OP_R, OP_T, OP_D, OP_N0: begin
                            op_d       = s_data[3:0];
                            last_idx_d = (s_data[3:0] == OP_N0) ? '0 : LAST_WORD;
                            if (s_last) begin
                                // Header carrying s_last is an early end of frame.
                                err_d    = 1'b1;
                                loaded_d = loaded_q & ~hdr_mask;
                            end else begin
                                state_d = ST_LOAD;
                            end
                        end
                        OP_GO: begin
                            if (!s_last) begin
                                err_d   = 1'b1;
                                state_d = ST_DRAIN;
                            end else if (loaded_q != ALL_LOADED) begin
                                err_d = 1'b1;
                            end else begin
                                state_d = ST_START;
                            end
                        end
                        OP_CLR: begin
                            if (!s_last) begin
                                err_d   = 1'b1;
                                state_d = ST_DRAIN;
                            end else begin
                                loaded_d = '0;
                                err_d    = 1'b0;
                            end
                        end
                        default: begin
                            err_d = 1'b1;
                            if (!s_last) begin
                                state_d = ST_DRAIN;
                            end
                        end
                    endcase
                end
            end

            ST_LOAD: begin
                if (accept) begin
                    unique case (op_q)
                        OP_C: begin
                            c_wren_d = 1'b1;
                            waddr_d  = wr_addr;
                            c_n_d    = s_data;
                        end
                        OP_N: begin
                            n_wren_d = 1'b1;
                            waddr_d  = wr_addr;
                            c_n_d    = s_data;
                        end
                        OP_R: begin
                            r_wren_d = 1'b1;
                            waddr_d  = wr_addr;
                            r_t_d    = s_data;
                        end
                        OP_T: begin
                            t_wren_d = 1'b1;
                            waddr_d  = wr_addr;
                            r_t_d    = s_data;
                        end
                        OP_D: begin
                            d_we = 1'b1;
                        end
                        default: begin
                            n0_d = s_data;
                        end
                    endcase

                    if (cnt_q == last_idx_q) begin
                        if (s_last) begin
                            loaded_d = loaded_q | op_mask;
                            state_d  = ST_IDLE;
                        end else begin
                            // Frame overran the operand: throw away the tail.
                            err_d    = 1'b1;
                            loaded_d = loaded_q & ~op_mask;
                            state_d  = ST_DRAIN;
                        end
                    end else if (s_last) begin
                        err_d    = 1'b1;
                        loaded_d = loaded_q & ~op_mask;
                        state_d  = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            ST_DRAIN: begin
                if (accept && s_last) begin
                    state_d = ST_IDLE;
                end
            end

            ST_START: begin
                cnt_d   = '0;
                state_d = ST_STREAM;
            end

            ST_STREAM: begin
                if (cnt_q == LAST_WORD) begin
                    cnt_d   = '0;
                    state_d = ST_GAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            // Two idle cycles let ModExp finish LOADC before startCompute.
            ST_GAP: begin
                if (cnt_q == ADDR_W'(1)) begin
                    cnt_d   = '0;
                    state_d = ST_KICK;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_KICK: begin
                if (cnt_q == ADDR_W'(1)) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        s_ready_d = (state_d == ST_IDLE) || (state_d == ST_LOAD) || (state_d == ST_DRAIN);
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    always_comb begin
        startInput   = (state_q == ST_START);
        startCompute = (state_q == ST_KICK);
        busy         = (state_q == ST_START) || (state_q == ST_STREAM) ||
                       (state_q == ST_GAP)   || (state_q == ST_KICK);
        d_in0        = (state_q == ST_STREAM) ? d_mem_q[cnt_q] : '0;
    end

    assign s_ready    = s_ready_q;
    assign c_wren     = c_wren_q;
    assign n_wren     = n_wren_q;
    assign r_wren     = r_wren_q;
    assign t_wren     = t_wren_q;
    assign waddr      = waddr_q;
    assign c_n_datain = c_n_q;
    assign r_t_datain = r_t_q;
    assign n0_in      = n0_q;
    assign loaded     = loaded_q;
    assign err        = err_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_modexp_operand_loader.sv
// -----------------------------------------------------------------------------
// tb_modexp_operand_loader
//
// Directed bench for modexp_operand_loader: operand loads (held and gappy
// s_valid), full GO sequence timing, framing errors, unknown opcodes, GO
// refusal, and reset in the middle of a GO stream. Expected write addresses
// follow MODEXP_LOADER_MSW_FIRST_EN when it is defined for the build.
// -----------------------------------------------------------------------------
module tb_modexp_operand_loader;

    localparam int DW = 64;
    localparam int TA = 32;
    localparam int AW = 5;

    localparam logic [3:0] OP_C   = 4'd0;
    localparam logic [3:0] OP_N   = 4'd1;
    localparam logic [3:0] OP_R   = 4'd2;
    localparam logic [3:0] OP_T   = 4'd3;
    localparam logic [3:0] OP_D   = 4'd4;
    localparam logic [3:0] OP_N0  = 4'd5;
    localparam logic [3:0] OP_GO  = 4'd6;
    localparam logic [3:0] OP_CLR = 4'd7;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          s_valid = 1'b0;
    logic          s_last = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_ready;
    logic          c_wren, n_wren, r_wren, t_wren;
    logic [AW-1:0] waddr;
    logic [DW-1:0] c_n_datain, r_t_datain, n0_in, d_in0;
    logic          startInput, startCompute, busy, err;
    logic [5:0]    loaded;
    logic [2:0]    state_dbg;

    always #5 clk = ~clk;

    modexp_operand_loader #(.DATA_WIDTH(DW), .TOTAL_ADDR(TA), .ADDR_W(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .s_last       (s_last),
        .c_wren       (c_wren),
        .n_wren       (n_wren),
        .r_wren       (r_wren),
        .t_wren       (t_wren),
        .waddr        (waddr),
        .c_n_datain   (c_n_datain),
        .r_t_datain   (r_t_datain),
        .n0_in        (n0_in),
        .d_in0        (d_in0),
        .startInput   (startInput),
        .startCompute (startCompute),
        .loaded       (loaded),
        .busy         (busy),
        .err          (err),
        .state_dbg    (state_dbg)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int            tests = 0;
    int            fails = 0;
    logic [DW-1:0] exp_q[$];
    int            wr_which_q[$];
    int            wr_addr_q[$];
    logic [DW-1:0] wr_data_q[$];
    int            wr_cyc_q[$];
    int            acc_cyc_q[$];
    int            si_cnt = 0;
    int            sc_cnt = 0;
    int            busy_cnt = 0;
    logic [DW-1:0] pl [40];
    logic [DW-1:0] d_exp [TA];

    // Passive monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (c_wren) begin
            wr_which_q.push_back(0); wr_addr_q.push_back(int'(waddr));
            wr_data_q.push_back(c_n_datain); wr_cyc_q.push_back(cyc);
        end
        if (n_wren) begin
            wr_which_q.push_back(1); wr_addr_q.push_back(int'(waddr));
            wr_data_q.push_back(c_n_datain); wr_cyc_q.push_back(cyc);
        end
        if (r_wren) begin
            wr_which_q.push_back(2); wr_addr_q.push_back(int'(waddr));
            wr_data_q.push_back(r_t_datain); wr_cyc_q.push_back(cyc);
        end
        if (t_wren) begin
            wr_which_q.push_back(3); wr_addr_q.push_back(int'(waddr));
            wr_data_q.push_back(r_t_datain); wr_cyc_q.push_back(cyc);
        end
        if (s_valid && s_ready) acc_cyc_q.push_back(cyc);
        if (startInput) si_cnt++;
        if (startCompute) sc_cnt++;
        if (busy) busy_cnt++;
    end

    // ---------------- check helpers ----------------
    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checki(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_addr(input int k);
`ifdef MODEXP_LOADER_MSW_FIRST_EN
        return TA - 1 - k;
`else
        return k;
`endif
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_logs();
        wr_which_q.delete(); wr_addr_q.delete(); wr_data_q.delete();
        wr_cyc_q.delete(); acc_cyc_q.delete(); exp_q.delete();
    endtask

    task automatic fill(input logic [DW-1:0] base);
        for (int k = 0; k < 40; k++) pl[k] = base + DW'(k);
    endtask

    task automatic send_word(input logic [DW-1:0] d, input logic last, input bit gaps);
        bit acc;
        int budget;
        if (gaps && ($urandom_range(0, 1) == 1)) begin
            s_valid = 1'b0;
            step($urandom_range(1, 2));
        end
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        acc     = 1'b0;
        budget  = 0;
        while (!acc && budget < 100) begin
            acc = s_ready;
            step(1);
            budget++;
        end
        if (!acc) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: observed=no transfer expected=transfer within 100 cycles");
        end
    endtask

    // last_idx: payload index carrying s_last, -1 puts it on the header.
    task automatic send_frame(input logic [3:0] op, input int nwords, input int last_idx, input bit gaps);
        send_word({32'hA5A5_5A5A, 28'h0, op}, last_idx == -1, gaps);
        for (int k = 0; k < nwords; k++) send_word(pl[k], last_idx == k, gaps);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic check_writes(input int which, input int n, input bit consec);
        checki("wr_count", wr_which_q.size(), n);
        for (int k = 0; k < n && k < wr_which_q.size(); k++) begin
            checki("wr_sel", wr_which_q[k], which);
            checki("wr_addr", wr_addr_q[k], exp_addr(k));
            check("wr_data", wr_data_q[k], exp_q[k]);
            if (k + 1 < acc_cyc_q.size()) checki("wr_latency", wr_cyc_q[k], acc_cyc_q[k + 1] + 1);
            if (consec) checki("wr_consecutive", wr_cyc_q[k], wr_cyc_q[0] + k);
        end
    endtask

    task automatic load_op(input logic [3:0] op, input logic [DW-1:0] base, input bit gaps, input bit consec);
        int n;
        n = (op == OP_N0) ? 1 : TA;
        fill(base);
        clear_logs();
        for (int k = 0; k < n; k++) exp_q.push_back(pl[k]);
        send_frame(op, n, n - 1, gaps);
        step(2);
        if (op <= OP_T) begin
            check_writes(int'(op), n, consec);
        end else begin
            checki("no_store_write", wr_which_q.size(), 0);
        end
        if (op == OP_D) begin
            for (int k = 0; k < TA; k++) d_exp[exp_addr(k)] = pl[k];
        end
        if (op == OP_N0) check("n0_in", n0_in, exp_q[0]);
    endtask

    // ---------------- directed sequence ----------------
    int si0, sc0, b0;

    initial begin
        // Reset state
        reset = 1'b1;
        step(3);
        check("rst_s_ready", {63'b0, s_ready}, 64'd0);
        check("rst_busy", {63'b0, busy}, 64'd0);
        check("rst_start_input", {63'b0, startInput}, 64'd0);
        check("rst_start_compute", {63'b0, startCompute}, 64'd0);
        check("rst_wren", {60'b0, c_wren, n_wren, r_wren, t_wren}, 64'd0);
        check("rst_loaded", {58'b0, loaded}, 64'd0);
        check("rst_err", {63'b0, err}, 64'd0);
        check("rst_d_in0", d_in0, 64'd0);
        check("rst_n0_in", n0_in, 64'd0);
        reset = 1'b0;
        step(2);
        check("idle_s_ready", {63'b0, s_ready}, 64'd1);

        // C load, s_valid held
        load_op(OP_C, 64'h1000, 1'b0, 1'b1);
        check("loaded_c", {58'b0, loaded}, 64'h01);
        check("err_after_c", {63'b0, err}, 64'd0);

        // N load with random valid gaps
        load_op(OP_N, 64'h2000, 1'b1, 1'b0);
        check("loaded_cn", {58'b0, loaded}, 64'h03);

        load_op(OP_R, 64'h3000, 1'b0, 1'b0);
        load_op(OP_T, 64'h4000, 1'b0, 1'b0);
        check("loaded_cnrt", {58'b0, loaded}, 64'h0F);
        load_op(OP_D, 64'hD00D_0000_0000_0000, 1'b0, 1'b0);
        check("loaded_d", {58'b0, loaded}, 64'h1F);
        load_op(OP_N0, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0);
        check("loaded_all", {58'b0, loaded}, 64'h3F);

        // Full GO sequence; after send_frame we are in cycle T.
        si0 = si_cnt; sc0 = sc_cnt;
        send_frame(OP_GO, 0, -1, 1'b0);
        check("go_start_input", {63'b0, startInput}, 64'd1);
        check("go_busy_T", {63'b0, busy}, 64'd1);
        check("go_s_ready_T", {63'b0, s_ready}, 64'd0);
        check("go_d_in0_T", d_in0, 64'd0);
        for (int k = 0; k < TA; k++) begin
            step(1);
            check("go_d_in0", d_in0, d_exp[k]);
            check("go_sc_stream", {63'b0, startCompute}, 64'd0);
            if (k == 0) check("go_start_input_once", {63'b0, startInput}, 64'd0);
        end
        step(1);
        check("go_d_in0_after", d_in0, 64'd0);
        check("go_sc_T33", {63'b0, startCompute}, 64'd0);
        step(1);
        check("go_sc_T34", {63'b0, startCompute}, 64'd0);
        check("go_busy_T34", {63'b0, busy}, 64'd1);
        step(1);
        check("go_sc_T35", {63'b0, startCompute}, 64'd1);
        check("go_busy_T35", {63'b0, busy}, 64'd1);
        check("go_s_ready_T35", {63'b0, s_ready}, 64'd0);
        step(1);
        check("go_sc_T36", {63'b0, startCompute}, 64'd1);
        step(1);
        check("go_sc_T37", {63'b0, startCompute}, 64'd0);
        check("go_busy_T37", {63'b0, busy}, 64'd0);
        check("go_s_ready_T37", {63'b0, s_ready}, 64'd1);
        check("go_d_in0_T37", d_in0, 64'd0);
        check("go_loaded_kept", {58'b0, loaded}, 64'h3F);
        checki("go_si_pulses", si_cnt - si0, 1);
        checki("go_sc_cycles", sc_cnt - sc0, 2);

        // Early s_last on word 10
        fill(64'h5000);
        clear_logs();
        send_frame(OP_C, 11, 10, 1'b0);
        step(2);
        check("early_err", {63'b0, err}, 64'd1);
        check("early_loaded", {58'b0, loaded}, 64'h3E);
        check("early_s_ready", {63'b0, s_ready}, 64'd1);
        load_op(OP_C, 64'h6000, 1'b0, 1'b0);
        check("reload_loaded", {58'b0, loaded}, 64'h3F);
        check("reload_err_sticky", {63'b0, err}, 64'd1);

        // Missing s_last on final word: tail drained
        fill(64'h8000);
        clear_logs();
        send_frame(OP_C, 33, 32, 1'b0);
        step(2);
        checki("overrun_accepts", acc_cyc_q.size(), 34);
        checki("overrun_writes", wr_which_q.size(), 32);
        check("overrun_err", {63'b0, err}, 64'd1);
        check("overrun_loaded", {58'b0, loaded}, 64'h3E);

        send_frame(OP_CLR, 0, -1, 1'b0);
        step(2);
        check("clr_err", {63'b0, err}, 64'd0);
        check("clr_loaded", {58'b0, loaded}, 64'h00);

        // Unknown opcode with a 3-word tail
        fill(64'h9000);
        clear_logs();
        send_frame(4'h9, 3, 2, 1'b0);
        step(2);
        checki("unk_accepts", acc_cyc_q.size(), 4);
        checki("unk_no_writes", wr_which_q.size(), 0);
        check("unk_err", {63'b0, err}, 64'd1);
        check("unk_s_ready", {63'b0, s_ready}, 64'd1);

        // GO refused with N0 missing
        send_frame(OP_CLR, 0, -1, 1'b0);
        step(1);
        load_op(OP_C, 64'hA000, 1'b0, 1'b0);
        load_op(OP_N, 64'hB000, 1'b0, 1'b0);
        load_op(OP_R, 64'hC000, 1'b0, 1'b0);
        load_op(OP_T, 64'hE000, 1'b0, 1'b0);
        load_op(OP_D, 64'h7777_0000_0000_1000, 1'b0, 1'b0);
        check("partial_loaded", {58'b0, loaded}, 64'h1F);
        check("partial_err_clear", {63'b0, err}, 64'd0);
        si0 = si_cnt; sc0 = sc_cnt; b0 = busy_cnt;
        send_frame(OP_GO, 0, -1, 1'b0);
        step(40);
        checki("refused_si", si_cnt - si0, 0);
        checki("refused_sc", sc_cnt - sc0, 0);
        checki("refused_busy", busy_cnt - b0, 0);
        check("refused_err", {63'b0, err}, 64'd1);
        check("refused_s_ready", {63'b0, s_ready}, 64'd1);

        // Reset during GO stream word 12
        load_op(OP_N0, 64'hFEDC_BA98_7654_3210, 1'b0, 1'b0);
        check("pre_go_loaded", {58'b0, loaded}, 64'h3F);
        send_frame(OP_GO, 0, -1, 1'b0);
        step(13);
        check("midgo_d_in0", d_in0, d_exp[12]);
        check("midgo_busy", {63'b0, busy}, 64'd1);
        #1 reset = 1'b1;
        #1;
        check("rstgo_d_in0", d_in0, 64'd0);
        check("rstgo_sc", {63'b0, startCompute}, 64'd0);
        check("rstgo_si", {63'b0, startInput}, 64'd0);
        check("rstgo_busy", {63'b0, busy}, 64'd0);
        check("rstgo_loaded", {58'b0, loaded}, 64'h00);
        check("rstgo_s_ready", {63'b0, s_ready}, 64'd0);
        check("rstgo_err", {63'b0, err}, 64'd0);
        step(2);
        reset = 1'b0;
        step(2);
        check("post_rst_s_ready", {63'b0, s_ready}, 64'd1);
        check("post_rst_d_in0", d_in0, 64'd0);
        load_op(OP_C, 64'h7000, 1'b0, 1'b0);
        check("post_rst_loaded", {58'b0, loaded}, 64'h01);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
